// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a req/ack memory port.
// Optional retired-instruction counter is compiled in with `define MC_CTRL_RETIRE_CNT_EN.
`timescale 1ns/1ps

module mc_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       busy
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_op_bad;

  always_comb begin
    w_op_bad = 1'b1;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: w_op_bad = 1'b0;
      default:                                       w_op_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sticky until reset; the opcode is only judged while decoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE && w_op_bad) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_srca   = 1'b0;
    alu_srcb   = 2'b00;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        // ALU computes PC+4 while the instruction is read; both latch on ack.
        mem_req  = 1'b1;
        alu_srcb = 2'b01;
        ir_we    = mem_ack;
        pc_we    = mem_ack;
        if (mem_ack) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_srcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        w_next   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack) begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_srca = 1'b1;
        alu_op   = 2'b10;
        w_next   = S_RWB;
      end
      S_RWB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_ADDIEX: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        w_next   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        // Compare A-B; the target was precomputed during decode.
        alu_srca = 1'b1;
        alu_op   = 2'b01;
        pc_src   = 2'b01;
        pc_we    = zero;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic                w_retire;
  logic [RETIRE_W-1:0] r_retired;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEMWR:                                    w_retire = mem_ack;
      default:                                    w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign retired = r_retired;
`else
  // Counter width only matters when the counter exists.
  if (RETIRE_W < 1) begin : g_retire_w_unused
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction reference sequences from the opcode rules, randomized waits/ignored inputs.
`timescale 1ns/1ps

module tb_mc_ctrl;

  localparam int TB_RW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] op;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_srca;
  logic [1:0] alu_srcb, alu_op;
  logic       reg_we, mem_to_reg, illegal, busy;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [TB_RW-1:0] retired;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic             m_illegal;
  logic [TB_RW-1:0] m_retired;

  always #5 clk = ~clk;

  mc_ctrl #(.RETIRE_W(TB_RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .op         (op),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
`ifdef MC_CTRL_RETIRE_CNT_EN
    .retired    (retired),
`endif
    .busy       (busy)
  );

  // Expected output vector for a busy state:
  // {mem_req,mem_we,iord,ir_we,pc_we,pc_src,alu_srca,alu_srcb,alu_op,reg_we,mem_to_reg,illegal,busy}
  function automatic logic [15:0] ev(input int mr, input int mw, input int io, input int irw,
                                     input int pcw, input int ps, input int sa, input int sb,
                                     input int ao, input int rw, input int m2r);
    return {1'(mr), 1'(mw), 1'(io), 1'(irw), 1'(pcw), 2'(ps), 1'(sa), 2'(sb), 2'(ao),
            1'(rw), 1'(m2r), m_illegal, 1'b1};
  endfunction

  function automatic logic [15:0] dut_v();
    return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_srca, alu_srcb, alu_op,
            reg_we, mem_to_reg, illegal, busy};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare 1ns later, advance to next falling edge.
  task automatic cyc(input string nm, input logic r, input logic [5:0] o, input logic z,
                     input logic a, input logic [15:0] e);
    run = r; op = o; zero = z; mem_ack = a;
    #1;
    check(nm, 32'(dut_v()), 32'(e));
`ifdef MC_CTRL_RETIRE_CNT_EN
    check({nm, "_retired"}, 32'(retired), 32'(m_retired));
`endif
    @(negedge clk);
  endtask

  // Reference: the cycle-by-cycle output sequence of one instruction starting in FETCH.
  task automatic instr(input logic [5:0] o, input logic z, input int fw, input int mw,
                       output int ncyc);
    ncyc = 0;
    repeat (fw) begin
      cyc("fetch_wait", rb(), o, rb(), 1'b0, ev(1,0,0,0,0,0,0,1,0,0,0)); ncyc++;
    end
    cyc("fetch", rb(), o, rb(), 1'b1, ev(1,0,0,1,1,0,0,1,0,0,0)); ncyc++;
    cyc("decode", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,0,3,0,0,0)); ncyc++;
    case (o)
      OP_LW: begin
        cyc("memadr", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,1,2,0,0,0)); ncyc++;
        repeat (mw) begin
          cyc("memrd_wait", rb(), o, rb(), 1'b0, ev(1,0,1,0,0,0,0,0,0,0,0)); ncyc++;
        end
        cyc("memrd", rb(), o, rb(), 1'b1, ev(1,0,1,0,0,0,0,0,0,0,0)); ncyc++;
        cyc("memwb", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,0,0,0,1,1)); ncyc++;
        m_retired++;
      end
      OP_SW: begin
        cyc("memadr", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,1,2,0,0,0)); ncyc++;
        repeat (mw) begin
          cyc("memwr_wait", rb(), o, rb(), 1'b0, ev(1,1,1,0,0,0,0,0,0,0,0)); ncyc++;
        end
        cyc("memwr", rb(), o, rb(), 1'b1, ev(1,1,1,0,0,0,0,0,0,0,0)); ncyc++;
        m_retired++;
      end
      OP_R: begin
        cyc("exec", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,1,0,2,0,0)); ncyc++;
        cyc("rwb", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,0,0,0,1,0)); ncyc++;
        m_retired++;
      end
      OP_ADDI: begin
        cyc("addiex", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,1,2,0,0,0)); ncyc++;
        cyc("addiwb", rb(), o, rb(), rb(), ev(0,0,0,0,0,0,0,0,0,1,0)); ncyc++;
        m_retired++;
      end
      OP_BEQ: begin
        cyc("branch", rb(), o, z, rb(), ev(0,0,0,0,int'(z),1,1,0,1,0,0)); ncyc++;
        m_retired++;
      end
      OP_J: begin
        cyc("jump", rb(), o, rb(), rb(), ev(0,0,0,0,1,2,0,0,0,0,0)); ncyc++;
        m_retired++;
      end
      default: begin
        m_illegal = 1'b1;
        repeat (20) begin
          cyc("halt", rb(), o, rb(), rb(), 16'h0002); ncyc++;
        end
      end
    endcase
    $display("instr op=%b zero=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d model_retired=%0d",
             o, z, fw, mw, ncyc, m_retired);
  endtask

  logic [5:0] legal_ops [6];
  int n;

  initial begin
    legal_ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    rst_n = 1'b0; run = 1'b0; op = 6'd0; zero = 1'b0; mem_ack = 1'b0;
    m_illegal = 1'b0; m_retired = '0;

    @(negedge clk);
    #1 check("reset_outputs", 32'(dut_v()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc("idle", 1'b0, 6'($urandom), rb(), rb(), 16'h0);
    cyc("idle_run", 1'b1, OP_R, rb(), rb(), 16'h0);

    // Directed instructions with literal cycle counts.
    instr(OP_R, 1'b0, 0, 0, n);    check("rtype_cycles", 32'(n), 32'd4);
    instr(OP_LW, 1'b0, 3, 3, n);   check("lw_wait3_cycles", 32'(n), 32'd11);
    instr(OP_BEQ, 1'b1, 0, 0, n);  check("beq_taken_cycles", 32'(n), 32'd3);
    instr(OP_BEQ, 1'b0, 0, 0, n);  check("beq_not_taken_cycles", 32'(n), 32'd3);
    instr(OP_ADDI, 1'b0, 0, 0, n); check("addi_cycles", 32'(n), 32'd4);
    instr(OP_SW, 1'b0, 0, 0, n);   check("sw_cycles", 32'(n), 32'd4);
    instr(OP_J, 1'b0, 0, 0, n);    check("j_cycles", 32'(n), 32'd3);
    instr(OP_LW, 1'b0, 0, 0, n);   check("lw_cycles", 32'(n), 32'd5);

    for (int i = 0; i < 150; i++) begin
      instr(legal_ops[$urandom_range(0, 5)], rb(), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), n);
    end

    // Asynchronous reset while a store waits on memory.
    cyc("fetch", 1'b0, OP_SW, 1'b0, 1'b1, ev(1,0,0,1,1,0,0,1,0,0,0));
    cyc("decode", 1'b0, OP_SW, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3,0,0,0));
    cyc("memadr", 1'b0, OP_SW, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,2,0,0,0));
    run = 1'b0; op = OP_SW; zero = 1'b0; mem_ack = 1'b0;
    #1 check("memwr_wait_before_reset", 32'(dut_v()), 32'(ev(1,1,1,0,0,0,0,0,0,0,0)));
    #1 rst_n = 1'b0;
    #1 check("reset_mid_memwr", 32'(dut_v()), 32'h0);
    m_illegal = 1'b0; m_retired = '0;
    @(negedge clk);
    check("reset_held", 32'(dut_v()), 32'h0);
    rst_n = 1'b1;
    cyc("idle_after_reset", 1'b0, OP_J, rb(), rb(), 16'h0);
    cyc("idle_run", 1'b1, OP_J, rb(), rb(), 16'h0);

    repeat (17) instr(OP_J, rb(), int'($urandom_range(0, 2)), 0, n);
`ifdef MC_CTRL_RETIRE_CNT_EN
    check("retired_after_17_jumps", 32'(retired), 32'd1);
`endif

    instr(OP_BAD, 1'b0, 1, 0, n);
    check("illegal_sticky", 32'(illegal), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("illegal_cleared", 32'({illegal, busy}), 32'd0);
    m_illegal = 1'b0; m_retired = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle_after_halt", 1'b0, OP_BAD, rb(), rb(), 16'h0);
    cyc("idle_run", 1'b1, OP_ADDI, rb(), rb(), 16'h0);
    instr(OP_ADDI, 1'b0, 2, 0, n); check("addi_after_halt_cycles", 32'(n), 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core.
- Sequences fetch, decode, execute, memory and writeback for each instruction, using the opcode field taken from the instruction register.
- Drives write enables and mux selects for the PC, IR, register file, ALU and a shared instruction/data memory port.
- Handshakes with memory through req/ack so that slow memory stalls the machine cleanly.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  core clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  leave IDLE and begin fetching when high
- op  input  6  opcode, ir[31:26] of the currently latched instruction
- zero  input  1  ALU zero flag, valid in BRANCH
- mem_ack  input  1  memory completed the current request this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  memory write (valid with mem_req)
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register
- ir_we  output  1  load instruction register
- pc_we  output  1  load PC
- pc_src  output  2  00 = PC+4, 01 = branch target, 10 = jump target {pc[31:28], ind, 2'b00}
- alu_srca  output  1  0 = PC, 1 = register A
- alu_srcb  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = decode from funct
- reg_we  output  1  register file write
- mem_to_reg  output  1  writeback data: 0 = ALU result, 1 = memory data register
- illegal  output  1  sticky; set on an unsupported opcode
- busy  output  1  high in every state except IDLE and HALT

Behaviour:
- Reset:
  - rst_n low forces state to IDLE immediately (asynchronous).
  - In IDLE every output is 0.
  - illegal clears only on reset.
  - Reset in the middle of a memory access drops mem_req in the same cycle; no PC, IR or register write occurs.
- Outputs are a Moore decode of the state, except strobes that are qualified by mem_ack or zero, which are stated per state below.
- State encoding is 4-bit.
- States and transitions:
  - IDLE: go to FETCH when run = 1; otherwise stay.
  - FETCH:
    - Outputs: mem_req = 1, iord = 0, alu_srca = 0, alu_srcb = 01, alu_op = 00, pc_src = 00.
    - ir_we = pc_we = mem_ack.
    - Stay in FETCH while mem_ack = 0; go to DECODE when mem_ack = 1.
  - DECODE:
    - Outputs: alu_srca = 0, alu_srcb = 11, alu_op = 00 (precomputes the branch target).
    - Next state by op:
      - 100011 (lw) or 101011 (sw) -> MEMADR
      - 000000 (R-type) -> EXEC
      - 001000 (addi) -> ADDIEX
      - 000100 (beq) -> BRANCH
      - 000010 (j) -> JUMP
      - anything else -> HALT, and illegal is set
  - MEMADR: alu_srca = 1, alu_srcb = 10, alu_op = 00. Go to MEMRD if op = 100011, else MEMWR.
  - MEMRD: mem_req = 1, iord = 1. Stay while mem_ack = 0; go to MEMWB on ack.
  - MEMWB: reg_we = 1, mem_to_reg = 1; go to FETCH.
  - MEMWR: mem_req = 1, mem_we = 1, iord = 1. Stay while mem_ack = 0; go to FETCH on ack.
  - EXEC: alu_srca = 1, alu_srcb = 00, alu_op = 10; go to RWB.
  - RWB: reg_we = 1, mem_to_reg = 0; go to FETCH.
  - ADDIEX: alu_srca = 1, alu_srcb = 10, alu_op = 00; go to ADDIWB.
  - ADDIWB: reg_we = 1, mem_to_reg = 0; go to FETCH.
  - BRANCH: alu_srca = 1, alu_srcb = 00, alu_op = 01, pc_src = 01, pc_we = zero; go to FETCH.
  - JUMP: pc_src = 10, pc_we = 1; go to FETCH.
  - HALT: all strobes 0; stays in HALT until reset.
- Destination register select (rt vs rd) is handled outside this block; this block only asserts reg_we.
- mem_ack outside FETCH, MEMRD and MEMWR is ignored.
- mem_req stays high and address selects stay stable for the whole wait; request inputs never change while mem_ack = 0.
- run is sampled only in IDLE; deasserting run mid-instruction has no effect.
- Cycle counts with zero-wait memory (mem_ack high in the first cycle):
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro: MC_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output port retired [RETIRE_W-1:0].
  - retired resets to 0 and increments by 1 on the final cycle of each instruction: MEMWB, MEMWR with ack, RWB, ADDIWB, BRANCH, JUMP.
  - Wraps modulo 2^RETIRE_W.
  - HALT does not count.
- When not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then run = 1, op = 000000, mem_ack always 1 -> state sequence IDLE, FETCH, DECODE, EXEC, RWB, FETCH; reg_we high exactly 1 cycle with mem_to_reg = 0.
- lw (op = 100011) with mem_ack delayed 3 cycles in both FETCH and MEMRD -> mem_req held 4 cycles each; iord = 0 then 1; reg_we with mem_to_reg = 1 in MEMWB; total 11 cycles.
- beq (op = 000100) with zero = 1, then again with zero = 0 -> pc_we = 1 with pc_src = 01 in the first case; pc_we = 0 in BRANCH in the second; both return to FETCH.
- Unsupported op = 111111 -> DECODE goes to HALT; illegal = 1 and busy = 0, held for 20 cycles; rst_n pulse clears illegal and returns to IDLE.
- rst_n asserted mid-MEMWR while waiting on mem_ack -> mem_req and mem_we drop to 0 in the same cycle with no clock edge; state is IDLE.
- With MC_CTRL_RETIRE_CNT_EN and RETIRE_W = 4: run 17 back-to-back j instructions -> retired reads 1.
